// File: rtl/sin_period_meas.sv
// rtl/sin_period_meas.sv - rising zero-crossing period and peak-amplitude meter for a sampled tone
// Schmitt-qualified crossings delimit periods; 2**AVG_LOG2 periods are averaged per result.
module sin_period_meas #(
    parameter int HYST     = 256,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD_W = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    input  logic [15:0]         in_i,
    output logic [PERIOD_W-1:0] period_o,
    output logic [15:0]         amplitude_o,
    output logic                out_valid_o,
    output logic                locked_o,
    output logic                timeout_o
);

    localparam int ACC_W  = PERIOD_W + AVG_LOG2 + 1;
    localparam int NPER_W = AVG_LOG2 + 1;
    localparam logic [PERIOD_W-1:0] CMAX      = '1;
    localparam logic [NPER_W-1:0]   NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {SEARCH, MEASURE} state_e;

    state_e                state_q, state_d;
    logic                  pol_q, pol_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [NPER_W-1:0]     nper_q, nper_d;
    logic [15:0]           peak_q, peak_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [15:0]           amp_q, amp_d;
    logic                  out_valid_q, out_valid_d;
    logic                  locked_q, locked_d;
    logic                  timeout_q, timeout_d;

    logic signed [15:0]    in_s;
    logic                  above, below, xr;
    logic [15:0]           mag, peak_max;
    logic [PERIOD_W:0]     p;
    logic [ACC_W-1:0]      acc_sum;

    assign in_s  = $signed(in_i);
    assign above = (int'(in_s) >= HYST);
    assign below = (int'(in_s) <= -HYST);
    assign xr    = in_valid_i & ~pol_q & above;

    // -32768 has no positive 16-bit counterpart, so it clamps to full scale
    always_comb begin
        if (in_i == 16'h8000)  mag = 16'h7FFF;
        else if (in_i[15])     mag = ~in_i + 16'd1;
        else                   mag = in_i;
    end

    assign peak_max = (mag > peak_q) ? mag : peak_q;
    assign p        = {1'b0, cnt_q} + 1'b1;
    assign acc_sum  = acc_q + ACC_W'(p);

    always_comb begin
        state_d     = state_q;
        pol_d       = pol_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        nper_d      = nper_q;
        peak_d      = peak_q;
        period_d    = period_q;
        amp_d       = amp_q;
        out_valid_d = 1'b0;
        locked_d    = locked_q;
        timeout_d   = 1'b0;

        if (in_valid_i) begin
            if (above)      pol_d = 1'b1;
            else if (below) pol_d = 1'b0;
        end

        case (state_q)
            SEARCH: begin
                if (xr) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    nper_d  = '0;
                    peak_d  = mag;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (xr) begin
                    cnt_d = '0;
                    if (nper_q == NPER_LAST) begin
                        period_d    = PERIOD_W'(acc_sum >> AVG_LOG2);
                        amp_d       = peak_max;
                        out_valid_d = 1'b1;
                        locked_d    = 1'b1;
                        acc_d       = '0;
                        nper_d      = '0;
                        // the closing crossing also opens the next window
                        peak_d      = mag;
                    end else begin
                        acc_d  = acc_sum;
                        nper_d = nper_q + 1'b1;
                        peak_d = peak_max;
                    end
                end else if (in_valid_i) begin
                    if (cnt_q == CMAX) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = SEARCH;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        peak_d = peak_max;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            pol_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            nper_q      <= '0;
            peak_q      <= '0;
            period_q    <= '0;
            amp_q       <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pol_q       <= pol_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            nper_q      <= nper_d;
            peak_q      <= peak_d;
            period_q    <= period_d;
            amp_q       <= amp_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period_o    = period_q;
    assign amplitude_o = amp_q;
    assign out_valid_o = out_valid_q;
    assign locked_o    = locked_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_sin_period_meas.sv
// tb/tb_sin_period_meas.sv - directed tone stimulus with a window-level reference model
module tb_sin_period_meas;

    localparam int PW   = 8;
    localparam int AVG  = 2;
    localparam int HYST = 256;
    localparam int NWIN = 1 << AVG;
    localparam int CMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   in_d;
    logic [PW-1:0] period;
    logic [15:0]   amplitude;
    logic          out_valid, locked, timeout;

    always #5 clk = ~clk;

    sin_period_meas #(.HYST(HYST), .AVG_LOG2(AVG), .PERIOD_W(PW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_i        (in_d),
        .period_o    (period),
        .amplitude_o (amplitude),
        .out_valid_o (out_valid),
        .locked_o    (locked),
        .timeout_o   (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_ov     = 0;
    int n_to     = 0;

    // reference model: periods of the open window are kept as a list
    bit m_pol, m_measuring;
    int m_since, m_peak;
    int m_win[$];
    int e_period, e_amp;
    bit e_ov, e_lock, e_to;

    function automatic int mag(int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_pol = 0; m_measuring = 0; m_since = 0; m_peak = 0;
        m_win.delete();
        e_period = 0; e_amp = 0; e_ov = 0; e_lock = 0; e_to = 0;
    endfunction

    function automatic void model_step(bit v, int x);
        bit xr;
        int sum;
        e_ov = 0;
        e_to = 0;
        if (!v) return;
        xr = !m_pol && (x >= HYST);
        if (x >= HYST) m_pol = 1;
        else if (x <= -HYST) m_pol = 0;
        if (!m_measuring) begin
            if (xr) begin
                m_measuring = 1;
                m_since = 0;
                m_win.delete();
                m_peak = mag(x);
            end
            return;
        end
        if (xr) begin
            m_win.push_back(m_since + 1);
            m_since = 0;
            if (m_win.size() == NWIN) begin
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                e_period = (sum / NWIN) % (1 << PW);
                e_amp    = imax(m_peak, mag(x));
                e_ov     = 1;
                e_lock   = 1;
                m_win.delete();
                m_peak   = mag(x);
            end else begin
                m_peak = imax(m_peak, mag(x));
            end
        end else if (m_since == CMAX) begin
            e_to = 1;
            e_lock = 0;
            m_measuring = 0;
        end else begin
            m_since++;
            m_peak = imax(m_peak, mag(x));
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cmp_out_valid", int'(out_valid), int'(e_ov));
            chk("cmp_timeout",   int'(timeout),   int'(e_to));
            chk("cmp_locked",    int'(locked),    int'(e_lock));
            chk("cmp_period",    int'(period),    e_period);
            chk("cmp_amplitude", int'(amplitude), e_amp);
            if (out_valid === 1'b1) n_ov++;
            if (timeout === 1'b1)   n_to++;
        end
    end

    task automatic step(bit v, int x);
        @(negedge clk);
        in_valid = v;
        in_d     = 16'(x);
        model_step(v, x);
    endtask

    task automatic settle();
        step(0, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic tone(int p, int hi, int lo, int nper, bit gaps);
        for (int n = 0; n < nper; n++)
            for (int k = 0; k < p; k++) begin
                step(1, (k < p / 2) ? hi : lo);
                if (gaps) step(0, 0);
            end
    endtask

    task automatic noisy(int a, int nper);
        for (int n = 0; n < nper; n++)
            for (int k = 0; k < 100; k++) begin
                if (k < 30)      step(1, a);
                else if (k < 50) step(1, (k % 2) ? -200 : 200);
                else if (k < 80) step(1, -a);
                else             step(1, (k % 2) ? 200 : -200);
            end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 0;
        in_valid = 0;
        model_reset();
        #1;
        chk("rst_period",    int'(period),    0);
        chk("rst_amplitude", int'(amplitude), 0);
        chk("rst_locked",    int'(locked),    0);
        chk("rst_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    int n0;

    initial begin
        rst_n = 0;
        in_valid = 0;
        in_d = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_period",    int'(period),    0);
        chk("reset_amplitude", int'(amplitude), 0);
        chk("reset_locked",    int'(locked),    0);
        chk("reset_timeout",   int'(timeout),   0);
        rst_n = 1;

        // steady tone: nothing before the fifth crossing
        tone(100, 10000, -10000, 4, 0);
        settle();
        chk("t1_no_early_result", n_ov, 0);
        chk("t1_not_locked", int'(locked), 0);
        tone(100, 10000, -10000, 5, 0);
        settle();
        chk("t1_period", int'(period), 100);
        chk("t1_amplitude", int'(amplitude), 10000);
        chk("t1_locked", int'(locked), 1);
        chk("t1_result_count", n_ov, 2);

        for (int i = 0; i < 8; i++) tone((i % 2) ? 101 : 100, 12000, -12000, 1, 0);
        settle();
        chk("t2_period_floor", int'(period), 100);
        chk("t2_amplitude", int'(amplitude), 12000);

        noisy(9000, 9);
        settle();
        chk("t3_period", int'(period), 100);
        chk("t3_amplitude", int'(amplitude), 9000);
        chk("t3_locked", int'(locked), 1);

        n0 = n_to;
        for (int i = 0; i < 300; i++) step(1, 0);
        settle();
        chk("t4_timeout_pulses", n_to - n0, 1);
        chk("t4_unlocked", int'(locked), 0);
        tone(100, 10000, -10000, 4, 0);
        settle();
        chk("t4_still_unlocked", int'(locked), 0);
        tone(100, 10000, -10000, 5, 0);
        settle();
        chk("t4_relocked", int'(locked), 1);
        chk("t4_period", int'(period), 100);

        tone(50, 10000, -10000, 9, 1);
        settle();
        chk("t5_period_gaps", int'(period), 50);

        tone(100, 1000, -32768, 9, 0);
        settle();
        chk("t6_amplitude_sat", int'(amplitude), 32767);
        chk("t6_period", int'(period), 100);
        tone(100, 1000, -32768, 1, 0);
        for (int k = 0; k < 30; k++) step(1, 1000);
        pulse_reset();
        n0 = n_ov;
        tone(100, 1000, -32768, 4, 0);
        settle();
        chk("t6_no_result_after_rst", n_ov - n0, 0);
        chk("t6_period_still_zero", int'(period), 0);
        step(1, 1000);
        settle();
        chk("t6_result_after_window", n_ov - n0, 1);
        chk("t6_period_after_rst", int'(period), 100);
        chk("t6_amp_after_rst", int'(amplitude), 32767);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
